uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between two character sources: requester 0 is the switch/button input path, and requester 1 is the receiver echo path. Each source has a one-entry holding slot. A round-robin arbiter picks the next character, optionally converts it to upper case, and drives the transmitter enable for a fixed number of 16x-baud clock cycles. It then waits for the transmitter to go busy before serving the next character.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two character sources, the UART transmitter
// and the transmit arbiter.
//   master : drives requests/characters and tx_rdy (sources + transmitter side)
//   slave  : the arbiter; returns acks, tx_data/tx_en, grant, busy, timeout_err
interface uart_tx_arbiter_if;
  logic       req0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic [7:0] data1;
  logic       ack1;
  logic       tx_rdy;
  logic [7:0] tx_data;
  logic       tx_en;
  logic [1:0] grant;
  logic       busy;
  logic       timeout_err;

  modport master (
    output req0, data0, req1, data1, tx_rdy,
    input  ack0, ack1, tx_data, tx_en, grant, busy, timeout_err
  );

  modport slave (
    input  req0, data0, req1, data1, tx_rdy,
    output ack0, ack1, tx_data, tx_en, grant, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between the switch/button
// path (requester 0) and the receiver echo path (requester 1). Each source has
// a one-entry holding slot; the chosen character is optionally upper-cased and
// presented with tx_en for HOLD_CYCLES cycles, then the arbiter waits for the
// transmitter to go busy before serving the next character.
// Ports:
//   clk   : system clock (16x baud)
//   reset : synchronous, active-high
//   bus   : uart_tx_arbiter_if.slave (req/data/ack per source, tx_rdy in;
//           tx_data, tx_en, grant, busy, timeout_err out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no character owned; pick the next full slot
// WAIT_RDY | character loaded, waiting for tx_rdy (bounded by BUSY_TIMEOUT)
// SEND     | tx_en high for HOLD_CYCLES cycles
// DRAIN    | waiting for tx_rdy to drop (bounded by BUSY_TIMEOUT)
module uart_tx_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned BUSY_TIMEOUT = 255,
  parameter bit          UPCASE       = 1'b1
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_RDY, S_SEND, S_DRAIN} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] BUSY_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       abandon;

  logic [1:0] slot_full;
  logic [7:0] slot_data0, slot_data1;
  logic       last_grant;
  logic       ack0_q, ack1_q, timeout_q;
  logic [7:0] tx_data_q;
  logic [1:0] grant_q;

  logic [1:0] eligible;
  logic       sel_valid;
  logic       sel_idx;
  logic [7:0] sel_raw, sel_conv;

  // A slot is not offered to the arbiter while its ack is still out, which
  // puts WAIT_RDY two edges after the capture edge.
  always_comb begin
    eligible  = slot_full & ~{ack1_q, ack0_q};
    sel_valid = |eligible;
    sel_idx   = 1'b0;
    case (eligible)
      2'b10:   sel_idx = 1'b1;
      2'b11:   sel_idx = ~last_grant;
      default: sel_idx = 1'b0;
    endcase
    sel_raw  = sel_idx ? slot_data1 : slot_data0;
    sel_conv = sel_raw;
    if (UPCASE && (sel_raw >= 8'h61) && (sel_raw <= 8'h7A))
      sel_conv = sel_raw - 8'h20;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    abandon   = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_valid) begin
          state_nxt = S_WAIT_RDY;
          cnt_nxt   = 8'd0;
        end
      end
      S_WAIT_RDY: begin
        if (bus.tx_rdy) begin
          state_nxt = S_SEND;
          cnt_nxt   = 8'd0;
        end else if (cnt == BUSY_LAST) begin
          state_nxt = S_IDLE;
          abandon   = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_SEND: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_DRAIN: begin
        if (!bus.tx_rdy) begin
          state_nxt = S_IDLE;
        end else if (cnt == BUSY_LAST) begin
          state_nxt = S_IDLE;
          abandon   = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_full  <= 2'b00;
      slot_data0 <= 8'h00;
      slot_data1 <= 8'h00;
      last_grant <= 1'b1;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      timeout_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      grant_q    <= 2'b00;
    end else begin
      timeout_q <= abandon;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;

      if (state == S_IDLE && sel_valid) begin
        tx_data_q          <= sel_conv;
        last_grant         <= sel_idx;
        grant_q            <= sel_idx ? 2'b10 : 2'b01;
        slot_full[sel_idx] <= 1'b0;
      end else if (state != S_IDLE && state_nxt == S_IDLE) begin
        grant_q <= 2'b00;
      end

      // Capture needs an empty slot, so it never collides with the clear above.
      if (bus.req0 && !slot_full[0] && !ack0_q) begin
        slot_full[0] <= 1'b1;
        slot_data0   <= bus.data0;
        ack0_q       <= 1'b1;
      end
      if (bus.req1 && !slot_full[1] && !ack1_q) begin
        slot_full[1] <= 1'b1;
        slot_data1   <= bus.data1;
        ack1_q       <= 1'b1;
      end
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_en       = (state == S_SEND);
  assign bus.grant       = grant_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.HOLD_CYCLES(16), .BUSY_TIMEOUT(255), .UPCASE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;

  logic       req0_d = 1'b0, req1_d = 1'b0;
  logic [7:0] data0_d = 8'h00, data1_d = 8'h00;
  logic       rdy_manual = 1'b1;
  logic       rdy_auto = 1'b1;
  logic       auto_tx = 1'b0;

  assign bus.req0   = req0_d;
  assign bus.data0  = data0_d;
  assign bus.req1   = req1_d;
  assign bus.data1  = data1_d;
  assign bus.tx_rdy = auto_tx ? rdy_auto : rdy_manual;

  logic [7:0] pend0[$];
  logic [7:0] pend1[$];
  logic [7:0] sent_data[$];
  logic [1:0] sent_grant[$];
  int         sent_len[$];

  int         run_len = 0, ack0_cnt = 0, ack1_cnt = 0, to_cnt = 0, to_wide = 0;
  int         data_unstable = 0, busy_left = 0, pushes = 0, m_last = 1;
  logic [7:0] run_data = 8'h00;
  logic       mon_prev_to = 1'b0, tx_prev_en = 1'b0;

  // Requester 0: presents the head of its queue, holds it until acked.
  initial forever begin
    @(negedge clk);
    if (bus.ack0 === 1'b1 && pend0.size() > 0) void'(pend0.pop_front());
    if (pend0.size() > 0) begin
      req0_d  = 1'b1;
      data0_d = pend0[0];
    end else req0_d = 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (bus.ack1 === 1'b1 && pend1.size() > 0) void'(pend1.pop_front());
    if (pend1.size() > 0) begin
      req1_d  = 1'b1;
      data1_d = pend1[0];
    end else req1_d = 1'b0;
  end

  // Transmitter model: goes busy for a random time after each tx_en burst.
  initial forever begin
    @(negedge clk);
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) rdy_auto = 1'b1;
    end else if (tx_prev_en && !bus.tx_en) begin
      rdy_auto  = 1'b0;
      busy_left = $urandom_range(1, 20);
    end
    tx_prev_en = bus.tx_en;
  end

  // Monitor: one record per completed tx_en burst, plus pulse counters.
  always @(negedge clk) begin
    if (reset) begin
      run_len     = 0;
      mon_prev_to = 1'b0;
    end else begin
      if (bus.tx_en) begin
        if (run_len == 0) run_data = bus.tx_data;
        else if (bus.tx_data !== run_data) data_unstable++;
        run_len++;
      end else if (run_len != 0) begin
        sent_data.push_back(bus.tx_data);
        sent_grant.push_back(bus.grant);
        sent_len.push_back(run_len);
        run_len = 0;
      end
      if (bus.timeout_err === 1'b1) begin
        to_cnt++;
        if (mon_prev_to) to_wide++;
      end
      if (bus.ack0 === 1'b1) ack0_cnt++;
      if (bus.ack1 === 1'b1) ack1_cnt++;
      mon_prev_to = bus.timeout_err;
    end
  end

  function automatic logic [7:0] up(input logic [7:0] c);
    if (c >= "a" && c <= "z") return c - 8'd32;
    return c;
  endfunction

  function automatic logic [7:0] rand_char();
    return 8'($urandom_range(32, 126));
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sent(input int k, input int budget, input string tag);
    int n = 0;
    while (sent_data.size() < k && n < budget) begin tick(); n++; end
    chk(tag, 32'(sent_data.size() >= k), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 3000) begin tick(); n++; end
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (bus.tx_en !== 1'b1 && n < 600) begin tick(); n++; end
    chk(tag, 32'(bus.tx_en), 32'd1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (bus.busy !== 1'b1 && n < 50) begin tick(); n++; end
    chk(tag, 32'(bus.busy), 32'd1);
  endtask

  task automatic chk_sent(input int i, input logic [7:0] d, input logic [1:0] g, input string tag);
    logic [7:0] od = 8'hxx;
    logic [1:0] og = 2'bxx;
    int         ol = -1;
    if (i < sent_data.size()) begin
      od = sent_data[i];
      og = sent_grant[i];
      ol = sent_len[i];
    end
    chk({tag, "_data"}, 32'(od), 32'(d));
    chk({tag, "_grant"}, 32'(og), 32'(g));
    chk({tag, "_len"}, 32'(ol), 32'd16);
  endtask

  // Both requesters raise a character on the same edge; the model serves the
  // one that did not win last time first.
  task automatic do_pair(input logic [7:0] c0, input logic [7:0] c1, input string tag);
    int base = sent_data.size();
    logic [7:0] d_a, d_b;
    logic [1:0] g_a, g_b;
    if (m_last == 1) begin
      d_a = up(c0); g_a = 2'b01; d_b = up(c1); g_b = 2'b10;
    end else begin
      d_a = up(c1); g_a = 2'b10; d_b = up(c0); g_b = 2'b01;
    end
    pend0.push_back(c0);
    pend1.push_back(c1);
    pushes += 2;
    wait_sent(base + 2, 3000, {tag, "_wait"});
    wait_idle({tag, "_idle"});
    chk_sent(base, d_a, g_a, {tag, "_first"});
    chk_sent(base + 1, d_b, g_b, {tag, "_second"});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    m_last = 1;
  endtask

  initial begin : main
    int base, n, t_before, a0, a1, first, total;
    logic [7:0] c, c2, ca, cb, cc, exp0[$], exp1[$];

    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
    chk("rst_tx_en", 32'(bus.tx_en), 32'd0);
    chk("rst_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);

    // Single request, conversion and latency.
    base = sent_data.size();
    pend0.push_back(8'h70); pushes++;
    tick();
    tick();
    chk("lat_ack0_hi", 32'(bus.ack0), 32'd1);
    tick();
    chk("lat_ack0_lo", 32'(bus.ack0), 32'd0);
    chk("lat_still_idle", 32'(bus.busy), 32'd0);
    tick();
    chk("lat_wait_busy", 32'(bus.busy), 32'd1);
    chk("lat_wait_grant", 32'(bus.grant), 32'h1);
    chk("lat_wait_data", 32'(bus.tx_data), 32'h50);
    chk("lat_wait_en", 32'(bus.tx_en), 32'd0);
    tick();
    chk("lat_send_en", 32'(bus.tx_en), 32'd1);
    wait_sent(base + 1, 100, "single_wait");
    chk_sent(base, 8'h50, 2'b01, "single");
    tick(); tick();
    rdy_manual = 1'b0;
    tick();
    chk("single_drain_idle", 32'(bus.busy), 32'd0);
    chk("single_drain_grant", 32'(bus.grant), 32'd0);
    chk("single_no_timeout", 32'(to_cnt), 32'd0);
    rdy_manual = 1'b1;

    // Simultaneous requests, round-robin from reset.
    do_reset();
    auto_tx = 1'b1;
    do_pair(8'h41, 8'h42, "rr1");
    do_pair(rand_char(), rand_char(), "rr2");
    do_pair(8'h61, 8'h7B, "rr3");

    // Full slot holds off a second request from the same source.
    base = sent_data.size();
    pend0.push_back(8'h60); pushes++;
    wait_en("hold_en");
    a1 = ack1_cnt;
    pend1.push_back(8'h7A); pend1.push_back(8'h31); pushes += 2;
    repeat (6) tick();
    chk("hold_ack1_once", 32'(ack1_cnt), 32'(a1 + 1));
    repeat (8) tick();
    chk("hold_ack1_still", 32'(ack1_cnt), 32'(a1 + 1));
    wait_sent(base + 3, 3000, "hold_wait");
    wait_idle("hold_idle");
    chk_sent(base, 8'h60, 2'b01, "hold_x");
    chk_sent(base + 1, 8'h5A, 2'b10, "hold_y");
    chk_sent(base + 2, 8'h31, 2'b10, "hold_31");
    m_last = 1;

    // Ready never arrives: abandoned after 255 cycles in WAIT_RDY.
    auto_tx = 1'b0;
    rdy_manual = 1'b0;
    base = sent_data.size();
    t_before = to_cnt;
    c = rand_char();
    pend0.push_back(c); pushes++;
    wait_busy("rdyto_busy");
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < 400) begin tick(); n++; end
    chk("rdyto_cycles", 32'(n), 32'd255);
    chk("rdyto_idle", 32'(bus.busy), 32'd0);
    tick();
    chk("rdyto_pulse_end", 32'(bus.timeout_err), 32'd0);
    chk("rdyto_count", 32'(to_cnt), 32'(t_before + 1));
    chk("rdyto_no_send", 32'(sent_data.size()), 32'(base));

    // Ready arrives at cycle 100: sent normally, no error.
    c2 = rand_char();
    pend0.push_back(c2); pushes++;
    wait_busy("rdylate_busy");
    repeat (100) tick();
    rdy_manual = 1'b1;
    wait_sent(base + 1, 100, "rdylate_wait");
    rdy_manual = 1'b0;
    wait_idle("rdylate_idle");
    chk_sent(base, up(c2), 2'b01, "rdylate");
    chk("rdylate_no_timeout", 32'(to_cnt), 32'(t_before + 1));

    // Drain never sees busy: abandoned after 255 cycles, next char served.
    rdy_manual = 1'b1;
    base = sent_data.size();
    t_before = to_cnt;
    ca = rand_char();
    cb = rand_char();
    pend0.push_back(ca); pushes++;
    wait_en("drainto_en");
    pend1.push_back(cb); pushes++;
    wait_sent(base + 1, 100, "drainto_first");
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < 400) begin tick(); n++; end
    chk("drainto_cycles", 32'(n), 32'd255);
    chk("drainto_count", 32'(to_cnt), 32'(t_before + 1));
    wait_sent(base + 2, 100, "drainto_next");
    rdy_manual = 1'b0;
    wait_idle("drainto_idle");
    chk_sent(base, up(ca), 2'b01, "drainto_a");
    chk_sent(base + 1, up(cb), 2'b10, "drainto_b");
    chk("drainto_total", 32'(to_cnt), 32'(t_before + 1));
    m_last = 1;

    // Reset during SEND with both slots full.
    rdy_manual = 1'b1;
    ca = rand_char(); cb = rand_char(); cc = rand_char();
    first = (m_last == 1) ? 0 : 1;
    pend0.push_back(ca); pend1.push_back(cb); pushes += 2;
    wait_busy("rstmid_busy");
    if (first == 0) pend0.push_back(cc); else pend1.push_back(cc);
    pushes++;
    wait_en("rstmid_en");
    repeat (4) tick();
    a0 = ack0_cnt; a1 = ack1_cnt; t_before = to_cnt; base = sent_data.size();
    reset = 1'b1;
    tick();
    chk("rstmid_tx_en", 32'(bus.tx_en), 32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_grant", 32'(bus.grant), 32'd0);
    chk("rstmid_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
    chk("rstmid_timeout", 32'(bus.timeout_err), 32'd0);
    reset = 1'b0;
    m_last = 1;
    repeat (10) tick();
    chk("rstmid_slots_empty", 32'(bus.busy), 32'd0);
    chk("rstmid_no_ack", 32'(ack0_cnt + ack1_cnt), 32'(a0 + a1));
    chk("rstmid_no_send", 32'(sent_data.size()), 32'(base));
    chk("rstmid_no_to", 32'(to_cnt), 32'(t_before));
    auto_tx = 1'b1;
    do_pair(rand_char(), rand_char(), "rstmid_tie");

    // Random traffic against a transmitter model.
    base = sent_data.size();
    t_before = to_cnt;
    total = 0;
    for (int i = 0; i < 60; i++) begin
      int r = $urandom_range(0, 3);
      if (r[0]) begin c = rand_char(); pend0.push_back(c); exp0.push_back(up(c)); total++; pushes++; end
      if (r[1]) begin c = rand_char(); pend1.push_back(c); exp1.push_back(up(c)); total++; pushes++; end
      repeat ($urandom_range(0, 25)) tick();
    end
    wait_sent(base + total, 20000, "rand_wait");
    wait_idle("rand_idle");
    for (int i = base; i < sent_data.size(); i++) begin
      logic [7:0] e = 8'hxx;
      if (sent_grant[i] == 2'b01 && exp0.size() > 0) e = exp0.pop_front();
      else if (sent_grant[i] == 2'b10 && exp1.size() > 0) e = exp1.pop_front();
      chk("rand_data", 32'(sent_data[i]), 32'(e));
      chk("rand_len", 32'(sent_len[i]), 32'd16);
    end
    chk("rand_left", 32'(exp0.size() + exp1.size()), 32'd0);
    chk("rand_no_timeout", 32'(to_cnt), 32'(t_before));

    chk("acks_total", 32'(ack0_cnt + ack1_cnt), 32'(pushes));
    chk("pend_drained", 32'(pend0.size() + pend1.size()), 32'd0);
    chk("tx_data_stable", 32'(data_unstable), 32'd0);
    chk("timeout_one_cycle", 32'(to_wide), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
